tlp_mwr_scheduler: RTL and testbench
====================================

# tlp_mwr_scheduler

Schedules memory-write DMA requests from `N_REQ` requesters onto the single TLP header generator path. It arbitrates round-robin and splits each request into Memory Write TLPs of at most `MAX_PAYLOAD_SIZE` bytes that never cross a 4 KB boundary. It emits one 3DW `tlp_memory_req_header` per TLP, with a rolling tag, to the downstream TLP assembler. The accompanying `hdr_src_o` selects the payload source.

## Interface
- `N_REQ`, 2, number of requesters (2..8)
- `MAX_PAYLOAD_SIZE`, 128, max payload in bytes, power of 2, 128..4096
- `clk` in 1: single clock
- `rst_n` in 1: reset, asynchronous and active-low
- `req_valid_i` in `N_REQ`: request valid per requester
- `req_ready_o` out `N_REQ`: request accepted (one-hot or zero)
- `req_addr_i` in `N_REQ`×32: byte start address, DW aligned; bits [1:0] are ignored
- `req_dw_i` in `N_REQ`×11: request length in DW, 0..1024
- `requester_id_i` in 16: BDF placed in every header; sampled at request accept
- `hdr_valid_o` out 1: header valid
- `hdr_ready_i` in 1: downstream accepts header
- `hdr_o` out 96: `tlp_memory_req_header`
- `hdr_src_o` out `$clog2(N_REQ)`: index of the requester owning `hdr_o`
- `hdr_last_o` out 1: `hdr_o` is the final TLP of its request
- `busy_o` out 1: request in progress (state ≠ IDLE)

## Operation
- FSM has two states: IDLE and SEND.
- **IDLE**
  - If any `req_valid_i` is set, the round-robin arbiter picks grant `g`. The search starts at `rr_ptr`.
  - `req_ready_o[g]`=1 in the same cycle (combinational from the registered `rr_ptr`).
  - On accept: capture `cur_addr`, `rem_dw` and `rid`, then go to SEND.
  - `req_dw_i`=0: accepted, generates no TLP, stays in IDLE, and `rr_ptr` still advances.
- **SEND**
  - Chunk length: `chunk = min(rem_dw, MPS_DW, (4096 − cur_addr[11:0])/4)`, where `MPS_DW = MAX_PAYLOAD_SIZE/4`.
  - Header fields: fmt=3'b010, type=5'b00000, tc/attr/td/ep/at/th/ln/ph=0, length={length_h,length_l}=chunk[9:0] (1024 encodes as 0).
  - Byte enables: first_dw_be=4'hF; last_dw_be=4'hF if chunk>1, else 4'h0.
  - Remaining header fields: requester_id=`rid`, tag=`tag_cnt`, address=`cur_addr[31:2]`.
  - On `hdr_valid_o && hdr_ready_i`:
    - `cur_addr += chunk*4`, `rem_dw −= chunk`, `tag_cnt++` (8-bit, wraps 255→0).
    - If `rem_dw` becomes 0: `rr_ptr = g+1` (mod `N_REQ`) and go to IDLE.
- `cur_addr` wraps at 2^32 with no error.
- Requests are never interleaved: all TLPs of one request are issued before the next grant.

## Timing
- **Reset values:** `req_ready_o`=0, `hdr_valid_o`=0, `hdr_o`=0, `hdr_src_o`=0, `hdr_last_o`=0, `busy_o`=0, `tag_cnt`=0, `rr_ptr`=0, state=IDLE.
- **Latency:** request accepted at cycle N → `hdr_valid_o`=1 at N+1.
- **Outputs:** `hdr_o`, `hdr_src_o` and `hdr_last_o` are registered. They hold stable while `hdr_valid_o && !hdr_ready_i`; `hdr_valid_o` never drops without a handshake.
- **Throughput:** one header per cycle under continuous `hdr_ready_i`. The next chunk's header is loaded in the cycle of the handshake.
- **Between requests:** after the last handshake, `hdr_valid_o`=0 and the FSM is in IDLE. A new accept is possible that same cycle, so there is exactly one bubble cycle.
- **Simultaneous valids:** lowest index at or above `rr_ptr` wins. Non-granted requesters see `req_ready_o`=0 and must hold their request.
- **Reset mid-request:** the request is dropped and all state returns to reset values immediately. Requesters re-issue.

## Structure
- Shared `PCIE_PKG` holds:
  - `tlp_memory_req_header`
  - `MAX_PAYLOAD_SIZE`
  - new constants `MPS_DW`, `TLP_FMT_3DW_DATA` (3'b010), `TLP_TYPE_MEM` (5'b00000) and `PCIE_4KB`
- Header field assembly is a package function: `create_mwr_header(addr, len, rid, tag)`.
- One sub-module, `rr_arbiter`: parameter `N`; inputs `req`, `ptr`; outputs one-hot `gnt` and `gnt_idx`. Purely combinational.
- Chunk computation and FSM live in `tlp_mwr_scheduler`.

## Test plan
- Req0 addr 0x1000, 16 DW, `hdr_ready_i`=1 → one header: length 16, addr field 0x400, tag 0, last_be F, `hdr_last_o`=1, `hdr_valid_o` one cycle after accept.
- Req0 addr 0x0, 100 DW → lengths 32, 32, 32, 4 on consecutive cycles; addresses 0x0, 0x80, 0x100, 0x180; tags 0..3; `hdr_last_o` only on the 4th.
- Req1 addr 0x0FF0, 8 DW → 4 DW @0x0FF0 then 4 DW @0x1000 (4 KB split). Req 1 DW @0x20 → last_be 0. Req 1024 DW @0x0 → 32 TLPs of length 32 (never an encoded 0).
- Req0 and Req1 valid together, then again after both complete → order 0, 1, then 0, 1.
- Backpressure:
  - Hold `hdr_ready_i`=0 for 5 cycles mid-request → `hdr_o` unchanged and valid held.
  - 300 headers issued → tag wraps 255→0.
  - `req_dw_i`=0 → accepted, no header, next requester is granted.
- Assert `rst_n`=0 mid-request → all outputs 0 the same cycle. After release, the next header has tag 0 and arbitration starts from requester 0.

Source files
------------

// File: rtl/tlp_mwr_scheduler_pkg.sv
// Shared PCIe definitions: 3DW memory request header layout, TLP constants and
// the Memory Write header builder.
package pcie_pkg;

  localparam int MAX_PAYLOAD_SIZE = 128;
  localparam int MPS_DW           = MAX_PAYLOAD_SIZE / 4;
  localparam int PCIE_4KB         = 4096;

  localparam logic [2:0] TLP_FMT_3DW_DATA = 3'b010;
  localparam logic [4:0] TLP_TYPE_MEM     = 5'b00000;

  // Wire order of a 3DW header, DW0 in the most significant bits.
  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  type_;
    logic        t9;
    logic [2:0]  tc;
    logic        t8;
    logic        attr_h;
    logic        ln;
    logic        th;
    logic        td;
    logic        ep;
    logic [1:0]  attr_l;
    logic [1:0]  at;
    logic [1:0]  length_h;
    logic [7:0]  length_l;
    logic [15:0] requester_id;
    logic [7:0]  tag;
    logic [3:0]  last_dw_be;
    logic [3:0]  first_dw_be;
    logic [29:0] address;
    logic [1:0]  ph;
  } tlp_memory_req_header;

  function automatic tlp_memory_req_header create_mwr_header(
    input logic [29:0] dw_addr,
    input logic [10:0] len,
    input logic [15:0] rid,
    input logic [7:0]  tag
  );
    tlp_memory_req_header h;
    h              = '0;
    h.fmt          = TLP_FMT_3DW_DATA;
    h.type_        = TLP_TYPE_MEM;
    h.length_h     = len[9:8];
    h.length_l     = len[7:0];
    h.first_dw_be  = 4'hF;
    h.last_dw_be   = (len > 11'd1) ? 4'hF : 4'h0;
    h.requester_id = rid;
    h.tag          = tag;
    h.address      = dw_addr;
    return h;
  endfunction

endpackage

// File: rtl/tlp_mwr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or above ptr
// (wrapping) wins.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] idx_s;
  logic          found_s;

  // Walk the requesters starting at ptr and keep the first one that is set.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 0; i < N; i++) begin
      idx_s      = IW'((int'(ptr) + i) % N);
      gnt[idx_s] = req[idx_s] & ~found_s;
      gnt_idx    = (req[idx_s] && !found_s) ? idx_s : gnt_idx;
      found_s    = found_s | req[idx_s];
    end
  end

endmodule

// File: rtl/tlp_mwr_scheduler.sv
// Round-robin Memory Write scheduler: splits DMA requests into MPS-limited,
// 4 KB-safe TLPs and emits one registered 3DW header per TLP.
module tlp_mwr_scheduler #(
  parameter int N_REQ = 2,
  parameter int MAX_PAYLOAD_SIZE = pcie_pkg::MAX_PAYLOAD_SIZE,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ-1:0][31:0] req_addr_i,
  input  logic [N_REQ-1:0][10:0] req_dw_i,
  input  logic [15:0]            requester_id_i,
  output logic                   hdr_valid_o,
  input  logic                   hdr_ready_i,
  output logic [95:0]            hdr_o,
  output logic [IW-1:0]          hdr_src_o,
  output logic                   hdr_last_o,
  output logic                   busy_o
);

  import pcie_pkg::*;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [10:0] CHUNK_MAX = 11'(MAX_PAYLOAD_SIZE / 4);
  localparam logic [10:0] PAGE_DW   = 11'(PCIE_4KB / 4);

  state_t               state_r;
  logic [IW-1:0]        rr_ptr_r;
  logic [7:0]           tag_cnt_r;
  logic [29:0]          cur_dwaddr_r;
  logic [10:0]          rem_dw_r;
  logic [15:0]          rid_r;
  tlp_memory_req_header hdr_r;

  logic [N_REQ-1:0]     gnt_s;
  logic [IW-1:0]        gnt_idx_s;
  logic                 accept_s;
  logic                 handshake_s;
  logic [29:0]          sel_dwaddr_s;
  logic [10:0]          sel_dw_s;
  logic [15:0]          sel_rid_s;
  logic [7:0]           sel_tag_s;
  logic [10:0]          room_s;
  logic [10:0]          mps_lim_s;
  logic [10:0]          chunk_s;
  logic [29:0]          next_dwaddr_s;
  logic [10:0]          next_rem_s;
  tlp_memory_req_header next_hdr_s;
  logic                 unused_addr_lsbs_s;

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] idx);
    logic [IW-1:0] nxt;
    if (idx == IW'(N_REQ - 1)) begin
      nxt = '0;
    end else begin
      nxt = idx + IW'(1);
    end
    return nxt;
  endfunction

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid_i),
    .ptr     (rr_ptr_r),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign accept_s    = (state_r == ST_IDLE) && (|req_valid_i);
  assign handshake_s = hdr_valid_o && hdr_ready_i;
  assign hdr_o       = hdr_r;
  assign busy_o      = (state_r == ST_SEND);

  // Requester handshake is only offered while idle and out of reset.
  always_comb begin
    if (rst_n && (state_r == ST_IDLE)) begin
      req_ready_o = gnt_s;
    end else begin
      req_ready_o = '0;
    end
  end

  // Byte-offset bits of the request addresses are ignored (DW aligned).
  always_comb begin
    unused_addr_lsbs_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      unused_addr_lsbs_s = unused_addr_lsbs_s ^ (^req_addr_i[i][1:0]);
    end
  end

  // Next chunk: first chunk comes from the granted request, later ones from
  // the in-flight registers; tag is pre-incremented for the handshake cycle.
  always_comb begin
    if (state_r == ST_SEND) begin
      sel_dwaddr_s = cur_dwaddr_r;
      sel_dw_s     = rem_dw_r;
      sel_rid_s    = rid_r;
      sel_tag_s    = tag_cnt_r + 8'd1;
    end else begin
      sel_dwaddr_s = req_addr_i[gnt_idx_s][31:2];
      sel_dw_s     = req_dw_i[gnt_idx_s];
      sel_rid_s    = requester_id_i;
      sel_tag_s    = tag_cnt_r;
    end
    room_s        = PAGE_DW - {1'b0, sel_dwaddr_s[9:0]};
    mps_lim_s     = (sel_dw_s < CHUNK_MAX) ? sel_dw_s : CHUNK_MAX;
    chunk_s       = (room_s < mps_lim_s) ? room_s : mps_lim_s;
    next_dwaddr_s = sel_dwaddr_s + {19'd0, chunk_s};
    next_rem_s    = sel_dw_s - chunk_s;
    next_hdr_s    = create_mwr_header(sel_dwaddr_s, chunk_s, sel_rid_s, sel_tag_s);
  end

  // Scheduler FSM with registered header outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= '0;
      tag_cnt_r    <= 8'd0;
      cur_dwaddr_r <= 30'd0;
      rem_dw_r     <= 11'd0;
      rid_r        <= 16'd0;
      hdr_r        <= '0;
      hdr_valid_o  <= 1'b0;
      hdr_src_o    <= '0;
      hdr_last_o   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (sel_dw_s == 11'd0) begin
              rr_ptr_r <= rr_next(gnt_idx_s);
            end else begin
              state_r      <= ST_SEND;
              rid_r        <= requester_id_i;
              cur_dwaddr_r <= next_dwaddr_s;
              rem_dw_r     <= next_rem_s;
              hdr_r        <= next_hdr_s;
              hdr_valid_o  <= 1'b1;
              hdr_src_o    <= gnt_idx_s;
              hdr_last_o   <= (next_rem_s == 11'd0);
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (handshake_s) begin
            tag_cnt_r <= tag_cnt_r + 8'd1;
            if (hdr_last_o) begin
              state_r     <= ST_IDLE;
              hdr_valid_o <= 1'b0;
              hdr_last_o  <= 1'b0;
              rr_ptr_r    <= rr_next(hdr_src_o);
            end else begin
              cur_dwaddr_r <= next_dwaddr_s;
              rem_dw_r     <= next_rem_s;
              hdr_r        <= next_hdr_s;
              hdr_last_o   <= (next_rem_s == 11'd0);
            end
          end else begin
            state_r <= ST_SEND;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          hdr_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlp_mwr_scheduler.sv
// Self-checking bench for tlp_mwr_scheduler against a transaction-level model
// that splits requests with plain arithmetic and tracks round-robin order.
module tb_tlp_mwr_scheduler;

  localparam int N      = 2;
  localparam int MPS    = 128;
  localparam int MPS_DW = MPS / 4;
  localparam int IW     = 1;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       req_valid_i;
  logic [N-1:0]       req_ready_o;
  logic [N-1:0][31:0] req_addr_i;
  logic [N-1:0][10:0] req_dw_i;
  logic [15:0]        requester_id_i;
  logic               hdr_valid_o;
  logic               hdr_ready_i;
  logic [95:0]        hdr_o;
  logic [IW-1:0]      hdr_src_o;
  logic               hdr_last_o;
  logic               busy_o;

  tlp_mwr_scheduler #(.N_REQ(N), .MAX_PAYLOAD_SIZE(MPS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_dw_i       (req_dw_i),
    .requester_id_i (requester_id_i),
    .hdr_valid_o    (hdr_valid_o),
    .hdr_ready_i    (hdr_ready_i),
    .hdr_o          (hdr_o),
    .hdr_src_o      (hdr_src_o),
    .hdr_last_o     (hdr_last_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] h;
    int          src;
    bit          last;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          failed = 0;
  int          cyc = 0;
  bit          m_busy;
  int          m_ptr;
  logic [7:0]  m_tag;
  int          ready_mode;
  logic [15:0] drv_rid;
  bit          pend_v[N];
  logic [31:0] pend_a[N];
  int          pend_d[N];

  function automatic logic [95:0] exp_hdr(logic [31:0] addr, int len, logic [15:0] rid, logic [7:0] tag);
    logic [9:0] l;
    logic [3:0] lbe;
    l   = 10'(len);
    lbe = (len > 1) ? 4'hF : 4'h0;
    return {3'b010, 5'b00000, 1'b0, 3'b000, 6'b000000, 2'b00, 2'b00, l,
            rid, tag, lbe, 4'hF, addr[31:2], 2'b00};
  endfunction

  task automatic build(int idx, logic [31:0] addr, int dw, logic [15:0] rid);
    logic [31:0] a;
    logic [7:0]  t;
    int          rem, c, room;
    exp_t        e;
    a   = addr & 32'hFFFF_FFFC;
    rem = dw;
    t   = m_tag;
    while (rem > 0) begin
      room = (4096 - int'(a % 32'd4096)) / 4;
      c = rem;
      if (c > MPS_DW) c = MPS_DW;
      if (c > room) c = room;
      e.h    = exp_hdr(a, c, rid, t);
      e.src  = idx;
      e.last = (rem == c);
      q.push_back(e);
      a   = a + 32'(c * 4);
      rem = rem - c;
      t   = t + 8'd1;
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = 1'b0;
    m_ptr  = 0;
    m_tag  = 8'd0;
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
  endtask

  task automatic submit(int idx, logic [31:0] addr, int dw);
    pend_v[idx] = 1'b1;
    pend_a[idx] = addr;
    pend_d[idx] = dw;
  endtask

  // One clock: check registered outputs, drive inputs, check ready, advance model.
  task automatic step();
    int           win;
    logic [N-1:0] exp_rdy;
    exp_t         e;
    tests++;
    if (hdr_valid_o !== m_busy) begin
      failed++;
      $display("FAIL hdr_valid cycle %0d got %b exp %b", cyc, hdr_valid_o, m_busy);
    end
    tests++;
    if (busy_o !== m_busy) begin
      failed++;
      $display("FAIL busy cycle %0d got %b exp %b", cyc, busy_o, m_busy);
    end
    if (m_busy && q.size() > 0) begin
      tests++;
      if (hdr_o !== q[0].h) begin
        failed++;
        $display("FAIL hdr cycle %0d got %h exp %h", cyc, hdr_o, q[0].h);
      end
      tests++;
      if (hdr_src_o !== IW'(q[0].src)) begin
        failed++;
        $display("FAIL hdr_src cycle %0d got %0d exp %0d", cyc, hdr_src_o, q[0].src);
      end
      tests++;
      if (hdr_last_o !== q[0].last) begin
        failed++;
        $display("FAIL hdr_last cycle %0d got %b exp %b", cyc, hdr_last_o, q[0].last);
      end
    end
    case (ready_mode)
      0:       hdr_ready_i = 1'b1;
      1:       hdr_ready_i = ($urandom_range(0, 3) != 0);
      default: hdr_ready_i = 1'b0;
    endcase
    drv_rid        = 16'($urandom);
    requester_id_i = drv_rid;
    for (int i = 0; i < N; i++) begin
      req_valid_i[i] = pend_v[i];
      req_addr_i[i]  = pend_a[i];
      req_dw_i[i]    = 11'(pend_d[i]);
    end
    #1;
    win = -1;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (win < 0 && pend_v[j]) win = j;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    tests++;
    if (req_ready_o !== exp_rdy) begin
      failed++;
      $display("FAIL req_ready cycle %0d got %b exp %b", cyc, req_ready_o, exp_rdy);
    end
    if (m_busy) begin
      if (hdr_ready_i) begin
        e = q.pop_front();
        m_tag = m_tag + 8'd1;
        if (e.last) begin
          m_busy = 1'b0;
          m_ptr  = (e.src + 1) % N;
        end
      end
    end else if (win >= 0) begin
      pend_v[win] = 1'b0;
      if (pend_d[win] == 0) begin
        m_ptr = (win + 1) % N;
      end else begin
        build(win, pend_a[win], pend_d[win], drv_rid);
        m_busy = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(int bound);
    int n;
    bit any;
    n = 0;
    any = 1'b1;
    while (any && n < bound) begin
      step();
      n++;
      any = m_busy;
      for (int i = 0; i < N; i++) any = any | pend_v[i];
    end
    tests++;
    if (any) begin
      failed++;
      $display("FAIL drain_timeout cycle %0d got busy %b exp idle within %0d", cyc, m_busy, bound);
      model_reset();
    end
    step();
  endtask

  task automatic check_reset_outputs(string tag);
    tests++;
    if (req_ready_o !== '0) begin failed++; $display("FAIL %s_req_ready got %b exp 0", tag, req_ready_o); end
    tests++;
    if (hdr_valid_o !== 1'b0) begin failed++; $display("FAIL %s_hdr_valid got %b exp 0", tag, hdr_valid_o); end
    tests++;
    if (hdr_o !== 96'd0) begin failed++; $display("FAIL %s_hdr got %h exp 0", tag, hdr_o); end
    tests++;
    if (hdr_src_o !== '0) begin failed++; $display("FAIL %s_hdr_src got %0d exp 0", tag, hdr_src_o); end
    tests++;
    if (hdr_last_o !== 1'b0) begin failed++; $display("FAIL %s_hdr_last got %b exp 0", tag, hdr_last_o); end
    tests++;
    if (busy_o !== 1'b0) begin failed++; $display("FAIL %s_busy got %b exp 0", tag, busy_o); end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    req_valid_i = '1;
    hdr_ready_i = 1'b1;
    #2;
    check_reset_outputs("reset");
    req_valid_i = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    ready_mode = 0;
    submit(0, 32'h0000_1000, 16);
    step();
    tests++;
    if (hdr_valid_o !== 1'b1) begin failed++; $display("FAIL single_latency got %b exp 1", hdr_valid_o); end
    tests++;
    if (hdr_o[73:64] !== 10'd16) begin failed++; $display("FAIL single_len got %0d exp 16", hdr_o[73:64]); end
    tests++;
    if (hdr_o[31:2] !== 30'h400) begin failed++; $display("FAIL single_addr got %h exp 400", hdr_o[31:2]); end
    tests++;
    if (hdr_o[47:40] !== 8'd0) begin failed++; $display("FAIL single_tag got %0d exp 0", hdr_o[47:40]); end
    tests++;
    if (hdr_o[39:36] !== 4'hF) begin failed++; $display("FAIL single_last_be got %h exp F", hdr_o[39:36]); end
    drain(50);
  endtask

  task automatic test_split();
    ready_mode = 0;
    submit(0, 32'h0000_0000, 100);
    drain(50);
  endtask

  task automatic test_4kb();
    ready_mode = 0;
    submit(1, 32'h0000_0FF0, 8);
    drain(50);
    submit(0, 32'h0000_0020, 1);
    drain(50);
    submit(1, 32'h0000_0000, 1024);
    drain(100);
  endtask

  task automatic test_arbitration();
    ready_mode = 0;
    for (int r = 0; r < 2; r++) begin
      submit(0, 32'h0000_0100, 2);
      submit(1, 32'h0000_0200, 40);
      drain(100);
    end
  endtask

  task automatic test_zero_len();
    ready_mode = 0;
    submit(0, 32'h0000_0040, 0);
    submit(1, 32'h0000_0080, 4);
    drain(50);
    submit(1, 32'h0000_0300, 0);
    drain(20);
    submit(0, 32'h0000_0400, 3);
    submit(1, 32'h0000_0500, 3);
    drain(50);
  endtask

  task automatic test_backpressure();
    ready_mode = 0;
    submit(0, 32'h0000_2000, 100);
    step();
    step();
    ready_mode = 2;
    for (int i = 0; i < 5; i++) step();
    ready_mode = 0;
    drain(50);
  endtask

  task automatic test_tag_wrap();
    ready_mode = 0;
    for (int i = 0; i < 10; i++) begin
      submit(i % N, 32'($urandom_range(0, 1023)) * 32'd4, 1024);
      drain(200);
    end
  endtask

  task automatic test_random();
    int idx, sel, dw;
    logic [31:0] addr;
    ready_mode = 1;
    for (int i = 0; i < 60; i++) begin
      idx = $urandom_range(0, N - 1);
      if (!pend_v[idx]) begin
        sel  = $urandom_range(0, 3);
        addr = (sel == 0) ? (32'hFFFF_F000 | 32'($urandom_range(0, 4095))) : 32'($urandom);
        dw   = (sel == 1) ? $urandom_range(0, 1024) : $urandom_range(0, 200);
        submit(idx, addr, dw);
      end
      for (int k = $urandom_range(0, 5); k > 0; k--) step();
    end
    drain(3000);
  endtask

  task automatic test_reset_mid();
    ready_mode = 0;
    submit(0, 32'h0000_3000, 100);
    step();
    step();
    step();
    req_valid_i[1] = 1'b1;
    req_dw_i[1]    = 11'd5;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    req_valid_i = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    submit(1, 32'h0000_0500, 5);
    submit(0, 32'h0000_0100, 3);
    step();
    tests++;
    if (hdr_src_o !== '0) begin failed++; $display("FAIL post_reset_src got %0d exp 0", hdr_src_o); end
    tests++;
    if (hdr_o[47:40] !== 8'd0) begin failed++; $display("FAIL post_reset_tag got %0d exp 0", hdr_o[47:40]); end
    drain(50);
  endtask

  initial begin
    rst_n          = 1'b1;
    req_valid_i    = '0;
    req_addr_i     = '0;
    req_dw_i       = '0;
    requester_id_i = 16'd0;
    hdr_ready_i    = 1'b0;
    ready_mode     = 0;
    model_reset();
    test_reset();
    test_single();
    test_split();
    test_4kb();
    test_arbitration();
    test_zero_len();
    test_backpressure();
    test_tag_wrap();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
